uart_tx_framer: RTL and testbench

//  - Byte-to-serial UART transmit stage: accepts bytes over a valid/ready handshake,

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_framer_if.sv | 12 +
 rtl/uart_tx_fifo.sv | 50 +++++
 rtl/uart_tx_framer.sv | 104 ++++++++++
 tb/tb_uart_tx_framer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Frame constants and TX state encoding shared by the UART transmit and receive sides.
package uart_pkg;

  localparam int   UART_FRAME_BITS = 10;
  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_START_BIT  = 1'b0;
  localparam logic UART_STOP_BIT   = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_framer_if.sv
// Byte handshake from the data source into the UART transmitter (valid/ready, accept on valid & ready).
interface uart_tx_framer_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_valid;
  logic                      tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with registered occupancy count; read data is the head entry (show-ahead).
// Single-cycle push/pop; full and empty decode from the registered count only.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_framer.sv
// 8N1 UART transmitter: FIFO-buffered bytes shifted out LSB first; push at edge N -> start bit on txd after N+2.
// Frames run back to back while bytes are buffered; tx_ready drops only when the FIFO is full.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  uart_tx_framer_if.slave              tx,
  output logic                         txd,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     LAST_BIT  = 4'(UART_FRAME_BITS - 1);

  uart_tx_state_t              state;
  uart_tx_state_t              state_nxt;
  logic [BW-1:0]               baud_cnt;
  logic [3:0]                  bit_cnt;
  logic [UART_FRAME_BITS-1:0]  frame;
  logic [UART_DATA_BITS-1:0]   head;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        push;
  logic                        pop;
  logic                        bit_end;
  logic                        frame_end;

  assign tx.tx_ready = ~fifo_full;
  assign push        = tx.tx_valid & ~fifo_full;
  assign bit_end     = (state == SEND) && (baud_cnt == BAUD_LAST);
  assign frame_end   = bit_end && (bit_cnt == LAST_BIT);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_dat (tx.tx_data),
    .pop      (pop),
    .pop_dat  (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = SEND;
      SEND:    if (frame_end && fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = ~fifo_empty;
      SEND:    pop = frame_end & ~fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  // The shift register idles at all ones, so txd simply follows frame[0] one cycle later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      frame    <= '1;
      txd      <= 1'b1;
    end else begin
      txd <= frame[0];
      if (pop) begin
        frame    <= {UART_STOP_BIT, head, UART_START_BIT};
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (state == SEND) begin
        if (bit_end) begin
          frame    <= {UART_STOP_BIT, frame[UART_FRAME_BITS-1:1]};
          baud_cnt <= '0;
          bit_cnt  <= bit_cnt + 4'd1;
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
      end
    end
  end

  assign busy = (state == SEND) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: exact-waveform vector table at 4 clocks/bit, hand-built corner
// sequences, and a random stream at 434 clocks/bit decoded by a bit-sampling line receiver.
module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  int         cyc = 0;
  int         n_pass = 0;
  int         n_total = 0;

  logic       txd_f, busy_f, txd_s, busy_s;
  logic [2:0] cnt_f, cnt_s;

  logic [7:0] expq_f[$], expq_s[$], rxq_f[$], rxq_s[$];
  int         gapq[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // expected txd levels, index 0 first on the wire
  } vec_t;
  vec_t vecs[4];

  uart_tx_framer_if if_f();
  uart_tx_framer_if if_s();

  uart_tx_framer #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_fast (
    .clock(clk), .reset(rst_n), .tx(if_f), .txd(txd_f), .busy(busy_f), .fifo_count(cnt_f)
  );
  uart_tx_framer #(.CLKS_PER_BIT(434), .FIFO_DEPTH(4)) u_slow (
    .clock(clk), .reset(rst_n), .tx(if_s), .txd(txd_s), .busy(busy_s), .fifo_count(cnt_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Receiver model: finds a start edge, samples each bit mid-period and flags any
  // line transition that does not fall on a whole bit period from the start edge.
  task automatic uart_mon(input int which, input int cpb);
    logic       prev, cur;
    int         pos, bad, last_end;
    logic [9:0] bits;
    prev = 1'b1; pos = -1; bad = 0; last_end = -1; bits = '1;
    forever begin
      @(negedge clk);
      cur = (which == 0) ? txd_f : txd_s;
      if (!rst_n) begin
        pos = -1; prev = 1'b1; last_end = -1;
        continue;
      end
      if (pos < 0 && prev && !cur) begin
        pos = 0; bad = 0;
        if (which == 0 && last_end >= 0) gapq.push_back(cyc - last_end - 1);
      end
      if (pos >= 0) begin
        if (cur != prev && (pos % cpb) != 0) bad++;
        if ((pos % cpb) == cpb / 2) bits[pos / cpb] = cur;
        if (pos == 10 * cpb - 1) begin
          check("start_bit", bits[0], 0);
          check("stop_bit", bits[9], 1);
          check("bit_timing", bad, 0);
          if (which == 0) rxq_f.push_back(bits[8:1]);
          else            rxq_s.push_back(bits[8:1]);
          last_end = cyc;
          pos = -1;
        end else begin
          pos++;
        end
      end
      prev = cur;
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input int which, input logic [7:0] b, output int waited);
    logic rdy;
    waited = 0;
    if (which == 0) begin if_f.tx_data = b; if_f.tx_valid = 1'b1; end
    else            begin if_s.tx_data = b; if_s.tx_valid = 1'b1; end
    rdy = (which == 0) ? if_f.tx_ready : if_s.tx_ready;
    while (!rdy && waited < 10000) begin
      @(posedge clk); #1;
      waited++;
      rdy = (which == 0) ? if_f.tx_ready : if_s.tx_ready;
    end
    check("push_ready", rdy, 1);
    @(posedge clk); #1;
    if (which == 0) begin if_f.tx_valid = 1'b0; expq_f.push_back(b); end
    else            begin if_s.tx_valid = 1'b0; expq_s.push_back(b); end
  endtask

  task automatic wait_idle_f();
    int w = 0;
    while (busy_f && w < 1000) begin @(posedge clk); #1; w++; end
    check("idle_wait", busy_f, 0);
  endtask

  task automatic wait_rx(input int which, input int limit);
    int w = 0;
    while (w < limit && ((which == 0) ? (rxq_f.size() < expq_f.size())
                                      : (rxq_s.size() < expq_s.size()))) begin
      @(posedge clk); #1; w++;
    end
  endtask

  task automatic cmp_q(input int which, input string tag);
    logic [7:0] r[$];
    logic [7:0] e[$];
    if (which == 0) begin r = rxq_f; e = expq_f; rxq_f.delete(); expq_f.delete(); end
    else            begin r = rxq_s; e = expq_s; rxq_s.delete(); expq_s.delete(); end
    check({tag, "_nbytes"}, r.size(), e.size());
    for (int i = 0; i < e.size() && i < r.size(); i++) check(tag, r[i], e[i]);
  endtask

  initial begin
    int         w, a;
    logic [7:0] burst[6];
    logic [7:0] b;

    vecs[0] = '{data: 8'hA5, line: 10'b1_1010_0101_0};
    vecs[1] = '{data: 8'h01, line: 10'b1_0000_0001_0};
    vecs[2] = '{data: 8'h80, line: 10'b1_1000_0000_0};
    vecs[3] = '{data: 8'h3C, line: 10'b1_0011_1100_0};
    burst   = '{8'h00, 8'hFF, 8'h55, 8'h3C, 8'h81, 8'h96};

    if_f.tx_valid = 1'b0; if_f.tx_data = '0;
    if_s.tx_valid = 1'b0; if_s.tx_data = '0;
    fork
      uart_mon(0, 4);
      uart_mon(1, 434);
    join_none

    // Reset state, then 100 idle cycles with no traffic
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", txd_f, 1);
    check("rst_busy", busy_f, 0);
    check("rst_ready", if_f.tx_ready, 1);
    check("rst_count", cnt_f, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_txd", txd_f, 1);
      check("idle_busy", busy_f, 0);
      check("idle_ready", if_f.tx_ready, 1);
      check("idle_count", cnt_f, 0);
    end
    check("idle_txd_slow", txd_s, 1);
    check("idle_busy_slow", busy_s, 0);
    check("idle_count_slow", cnt_s, 0);
    @(posedge clk); #1;

    // Single frames, cycle-exact line waveform
    for (int v = 0; v < 4; v++) begin
      wait_idle_f();
      push(0, vecs[v].data, w);
      check("txd_at_push", txd_f, 1);
      @(posedge clk); #1;
      check("txd_at_pop", txd_f, 1);
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        check("frame_bit", txd_f, vecs[v].line[k / 4]);
        if (k == 38) check("busy_in_stop", busy_f, 1);
      end
      check("busy_after_stop", busy_f, 0);
      check("txd_after_stop", txd_f, 1);
      check("count_after_stop", cnt_f, 0);
    end
    wait_rx(0, 200);
    cmp_q(0, "single_data");

    // Burst fills the FIFO; sixth byte must wait; frames contiguous
    wait_idle_f();
    gapq.delete();
    for (int i = 0; i < 5; i++) push(0, burst[i], w);
    check("burst_count_full", cnt_f, 4);
    check("burst_ready_low", if_f.tx_ready, 0);
    push(0, burst[5], w);
    check("burst_held", (w > 0), 1);
    wait_rx(0, 600);
    cmp_q(0, "burst_data");
    check("burst_nframes", gapq.size(), 6);
    for (int i = 1; i < gapq.size(); i++) check("burst_gap", gapq[i], 0);

    // Push on the very edge the FSM pops the next byte
    wait_idle_f();
    push(0, 8'hC3, w);
    a = cyc;
    push(0, 8'h5A, w);
    push(0, 8'hE7, w);
    while (cyc < a + 40) begin @(posedge clk); #1; end
    check("count_before_pop", cnt_f, 2);
    if_f.tx_data = 8'h24; if_f.tx_valid = 1'b1;
    @(posedge clk); #1;
    if_f.tx_valid = 1'b0;
    expq_f.push_back(8'h24);
    check("count_push_pop", cnt_f, 2);
    check("busy_push_pop", busy_f, 1);
    wait_rx(0, 400);
    cmp_q(0, "pushpop_data");

    // Reset in the middle of a frame with a byte still buffered
    wait_idle_f();
    push(0, 8'h00, w);
    a = cyc;
    push(0, 8'h5A, w);
    while (cyc < a + 18) begin @(posedge clk); #1; end
    check("pre_reset_txd", txd_f, 0);
    rst_n = 1'b0;
    #1;
    check("reset_txd", txd_f, 1);
    check("reset_count", cnt_f, 0);
    check("reset_busy", busy_f, 0);
    check("reset_ready", if_f.tx_ready, 1);
    expq_f.delete();
    rxq_f.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    push(0, 8'h3C, w);
    wait_rx(0, 200);
    cmp_q(0, "post_reset_data");

    // Random stream at the real baud divisor
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 1500)) @(posedge clk);
        #1;
      end
      push(1, b, w);
    end
    wait_rx(1, 60000);
    cmp_q(1, "slow_data");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
